// File: rtl/gray_seq_checker.sv
// gray_seq_checker: decodes a Gray-coded counter stream, checks that each
// accepted sample advances by exactly +1 (mod 2^WIDTH), and reports lock
// status, one-cycle step error pulses and a saturating error count.
//
// Build option: define GRAY_SYNC_EN to pass gray_in/gray_valid through a
// 2-flop synchronizer before decode (source counter in another clock domain).
// Latency from input to outputs is then 3 cycles instead of 1.
module gray_seq_checker #(
    parameter int WIDTH      = 3,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 gray_valid,
    input  logic                 clear_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 locked,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]           LOCK_CNT_C = LOCK_COUNT[3:0];
    localparam logic [ERR_CNT_W-1:0] ERR_MAX_C  = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE_C  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     BIN_ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] gray_s;
    logic             valid_s;

`ifdef GRAY_SYNC_EN
    logic [WIDTH-1:0] gray_meta_r;
    logic [WIDTH-1:0] gray_sync_r;
    logic             valid_meta_r;
    logic             valid_sync_r;

    // Two-flop synchronizer; Gray coding keeps the multi-bit word coherent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gray_meta_r  <= {WIDTH{1'b0}};
            gray_sync_r  <= {WIDTH{1'b0}};
            valid_meta_r <= 1'b0;
            valid_sync_r <= 1'b0;
        end else begin
            gray_meta_r  <= gray_in;
            gray_sync_r  <= gray_meta_r;
            valid_meta_r <= gray_valid;
            valid_sync_r <= valid_meta_r;
        end
    end

    assign gray_s  = gray_sync_r;
    assign valid_s = valid_sync_r;
`else
    assign gray_s  = gray_in;
    assign valid_s = gray_valid;
`endif

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       good_cnt_r;
    logic [3:0]       good_cnt_nxt_s;
    logic [WIDTH-1:0] prev_r;

    logic [WIDTH-1:0]     bin_s;
    logic [WIDTH-1:0]     prev_inc_s;
    logic                 good_s;
    logic                 stall_s;
    logic                 bad_s;

    logic [WIDTH-1:0]     bin_nxt_s;
    logic                 bin_valid_nxt_s;
    logic                 locked_nxt_s;
    logic                 step_err_nxt_s;
    logic [ERR_CNT_W-1:0] err_count_nxt_s;

    assign bin_s      = gray2bin(gray_s);
    assign prev_inc_s = prev_r + BIN_ONE_C;
    assign good_s     = (bin_s == prev_inc_s);
    assign stall_s    = (bin_s == prev_r);
    assign bad_s      = !good_s && !stall_s;

    // State, good-step counter and previous-sample registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_SEARCH;
            good_cnt_r <= 4'd0;
            prev_r     <= {WIDTH{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            good_cnt_r <= good_cnt_nxt_s;
            if (valid_s) begin
                prev_r <= bin_s;
            end else begin
                prev_r <= prev_r;
            end
        end
    end

    // Next-state and good-step counter update on each accepted sample.
    always_comb begin
        state_nxt_s    = state_r;
        good_cnt_nxt_s = good_cnt_r;
        if (valid_s) begin
            case (state_r)
                ST_SEARCH: begin
                    state_nxt_s    = ST_ACQUIRE;
                    good_cnt_nxt_s = 4'd0;
                end
                ST_ACQUIRE: begin
                    if (good_s) begin
                        if ((good_cnt_r + 4'd1) == LOCK_CNT_C) begin
                            state_nxt_s    = ST_LOCKED;
                            good_cnt_nxt_s = 4'd0;
                        end else begin
                            good_cnt_nxt_s = good_cnt_r + 4'd1;
                        end
                    end else if (stall_s) begin
                        good_cnt_nxt_s = good_cnt_r;
                    end else begin
                        good_cnt_nxt_s = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (bad_s) begin
                        state_nxt_s    = ST_ACQUIRE;
                        good_cnt_nxt_s = 4'd0;
                    end else begin
                        state_nxt_s    = ST_LOCKED;
                    end
                end
                default: begin
                    state_nxt_s    = ST_SEARCH;
                    good_cnt_nxt_s = 4'd0;
                end
            endcase
        end else begin
            state_nxt_s    = state_r;
            good_cnt_nxt_s = good_cnt_r;
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        bin_nxt_s       = bin_out;
        bin_valid_nxt_s = valid_s;
        locked_nxt_s    = (state_nxt_s == ST_LOCKED);
        step_err_nxt_s  = 1'b0;
        err_count_nxt_s = err_count;
        if (valid_s) begin
            bin_nxt_s      = bin_s;
            step_err_nxt_s = (state_r != ST_SEARCH) && bad_s;
        end else begin
            bin_nxt_s      = bin_out;
            step_err_nxt_s = 1'b0;
        end
        // Clear has priority over a same-cycle error increment.
        if (clear_err) begin
            err_count_nxt_s = {ERR_CNT_W{1'b0}};
        end else if (valid_s && (state_r == ST_LOCKED) && bad_s && (err_count != ERR_MAX_C)) begin
            err_count_nxt_s = err_count + ERR_ONE_C;
        end else begin
            err_count_nxt_s = err_count;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_out   <= {WIDTH{1'b0}};
            bin_valid <= 1'b0;
            locked    <= 1'b0;
            step_err  <= 1'b0;
            err_count <= {ERR_CNT_W{1'b0}};
        end else begin
            bin_out   <= bin_nxt_s;
            bin_valid <= bin_valid_nxt_s;
            locked    <= locked_nxt_s;
            step_err  <= step_err_nxt_s;
            err_count <= err_count_nxt_s;
        end
    end

endmodule

// File: tb/tb_gray_seq_checker.sv
// Self-checking bench for gray_seq_checker (default build, 1-cycle latency).
// A behavioural model pushes the expected outputs for each driven cycle into
// a scoreboard queue; they are popped and compared on the next falling edge.
module tb_gray_seq_checker;

    localparam int W = 3;

    logic         clk;
    logic         reset;
    logic [W-1:0] gray_in;
    logic         gray_valid;
    logic         clear_err;
    logic [W-1:0] bin_out;
    logic         bin_valid;
    logic         locked;
    logic         step_err;
    logic [1:0]   err_count;

    gray_seq_checker #(
        .WIDTH      (3),
        .LOCK_COUNT (4),
        .ERR_CNT_W  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_in    (gray_in),
        .gray_valid (gray_valid),
        .clear_err  (clear_err),
        .bin_out    (bin_out),
        .bin_valid  (bin_valid),
        .locked     (locked),
        .step_err   (step_err),
        .err_count  (err_count)
    );

    typedef struct {
        logic [W-1:0] bin;
        logic         bv;
        logic         lk;
        logic         se;
        logic [1:0]   ec;
    } exp_t;

    exp_t sb_q[$];

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state (0=search, 1=acquire, 2=locked).
    int           m_state;
    int           m_cnt;
    logic [W-1:0] m_prev;
    logic [W-1:0] m_bin;
    logic         m_bv;
    logic         m_se;
    logic [1:0]   m_err;
    int           cur;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] tb_decode(input logic [W-1:0] g);
        logic [W-1:0] b;
        logic         acc;
        acc = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_prev  = 3'd0;
        m_bin   = 3'd0;
        m_bv    = 1'b0;
        m_se    = 1'b0;
        m_err   = 2'd0;
    endtask

    task automatic model_step(input logic v, input logic [W-1:0] g, input logic clr);
        logic [W-1:0] b;
        exp_t         e;
        if (v) begin
            b    = tb_decode(g);
            m_bv = 1'b1;
            m_se = 1'b0;
            if (m_state == 0) begin
                m_state = 1;
                m_cnt   = 0;
            end else if (int'(b) == ((int'(m_prev) + 1) % 8)) begin
                if (m_state == 1) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == 4) begin
                        m_state = 2;
                        m_cnt   = 0;
                    end
                end
            end else if (b != m_prev) begin
                m_se  = 1'b1;
                m_cnt = 0;
                if (m_state == 2) begin
                    m_state = 1;
                    if (m_err != 2'd3) m_err = m_err + 2'd1;
                end
            end
            m_prev = b;
            m_bin  = b;
        end else begin
            m_bv = 1'b0;
            m_se = 1'b0;
        end
        if (clr) m_err = 2'd0;
        e.bin = m_bin;
        e.bv  = m_bv;
        e.lk  = (m_state == 2);
        e.se  = m_se;
        e.ec  = m_err;
        sb_q.push_back(e);
    endtask

    // Compare the pending expectation, then drive one cycle of stimulus.
    task automatic drive(input logic v, input int bval, input logic clr);
        exp_t         e;
        logic [W-1:0] b;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("bin_out",   {29'd0, bin_out},   {29'd0, e.bin});
            check_eq("bin_valid", {31'd0, bin_valid}, {31'd0, e.bv});
            check_eq("locked",    {31'd0, locked},    {31'd0, e.lk});
            check_eq("step_err",  {31'd0, step_err},  {31'd0, e.se});
            check_eq("err_count", {30'd0, err_count}, {30'd0, e.ec});
        end
        b          = W'(bval % 8);
        gray_valid = v;
        gray_in    = b ^ (b >> 1);
        clear_err  = clr;
        model_step(v, gray_in, clr);
    endtask

    task automatic relock(input int n);
        for (int i = 0; i < n; i++) begin
            cur = (cur + 1) % 8;
            drive(1'b1, cur, 1'b0);
        end
    endtask

    task automatic locked_error(input logic clr);
        cur = (cur + 3) % 8;
        drive(1'b1, cur, clr);
        relock(4);
    endtask

    initial begin
        reset      = 1'b0;
        gray_in    = 3'd0;
        gray_valid = 1'b0;
        clear_err  = 1'b0;
        model_reset();

        // Reset held with random inputs: outputs must stay zero.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("rst_bin",    {29'd0, bin_out},   32'd0);
            check_eq("rst_bvalid", {31'd0, bin_valid}, 32'd0);
            check_eq("rst_locked", {31'd0, locked},    32'd0);
            check_eq("rst_serr",   {31'd0, step_err},  32'd0);
            check_eq("rst_ecnt",   {30'd0, err_count}, 32'd0);
            gray_in    = 3'($urandom_range(0, 7));
            gray_valid = 1'($urandom_range(0, 1));
            clear_err  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        gray_valid = 1'b0;
        clear_err  = 1'b0;
        reset      = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 0, 1'b0);

        // Clean stream through the wrap, lock after the fifth sample.
        for (int i = 0; i < 12; i++) drive(1'b1, i, 1'b0);
        cur = 3;

        // Skip 3 -> 5 while locked, then relock.
        cur = 5;
        drive(1'b1, cur, 1'b0);
        relock(4);

        // Stall and gap: no error, lock held, bin_valid low in the gap.
        cur = (cur + 1) % 8;
        drive(1'b1, cur, 1'b0);
        drive(1'b1, cur, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, cur, 1'b0);
        relock(1);

        // Saturation: five more locked errors, count sticks at 3.
        for (int i = 0; i < 5; i++) locked_error(1'b0);
        drive(1'b0, cur, 1'b0);
        check_eq("sat_ecnt",   {30'd0, err_count}, 32'd3);
        check_eq("sat_locked", {31'd0, locked},    32'd1);

        // Clear on the same cycle as an error wins.
        locked_error(1'b1);
        drive(1'b0, cur, 1'b0);
        check_eq("clr_ecnt", {30'd0, err_count}, 32'd0);

        // Build err_count=2 while locked, then reset asynchronously.
        locked_error(1'b0);
        locked_error(1'b0);
        drive(1'b0, cur, 1'b0);
        check_eq("pre_rst_ecnt",   {30'd0, err_count}, 32'd2);
        check_eq("pre_rst_locked", {31'd0, locked},    32'd1);
        drive(1'b0, cur, 1'b0);
        @(negedge clk);
        sb_q.delete();
        #2 reset = 1'b0;
        #1;
        check_eq("async_locked", {31'd0, locked},    32'd0);
        check_eq("async_ecnt",   {30'd0, err_count}, 32'd0);
        check_eq("async_bin",    {29'd0, bin_out},   32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Re-acquire from SEARCH starting at an arbitrary value.
        cur = 6;
        drive(1'b1, cur, 1'b0);
        relock(6);

        // Random stream: mostly +1 steps, some stalls, jumps, gaps and clears.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6)       cur = (cur + 1) % 8;
            else if (r == 6) cur = cur;
            else             cur = $urandom_range(0, 7);
            drive(1'($urandom_range(0, 3) != 0), cur, 1'($urandom_range(0, 15) == 0));
        end
        drive(1'b0, cur, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
